// File: rtl/clk_200_reset_sequencer.sv
// Staged reset sequencer for the clk_200 domain: waits for a stable lock, holds off, then
// releases rst_out[0..NUM_STAGES-1] in order, restarting on lock loss or a software request.
module clk_200_reset_sequencer #(
  parameter int HOLD_CYCLES = 1024,
  parameter int STAGE_GAP   = 16,
  parameter int NUM_STAGES  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_200,
  input  logic                  reset,
  input  logic                  locked,
  input  logic                  sw_reset_req,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  seq_done,
  output logic [2:0]            seq_state,
  output logic [7:0]            reset_count
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(STAGE_GAP - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    ST_ASSERT    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  state_t                  state, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    locked_s;
  logic [HW-1:0]           hold_cnt, hold_cnt_d;
  logic [GW-1:0]           gap_cnt, gap_cnt_d;
  logic [SW-1:0]           stage, stage_d;
  logic [NUM_STAGES-1:0]   rst_out_d;
  logic                    seq_done_d;
  logic [7:0]              reset_count_d;

  assign locked_s  = sync_q[SYNC_STAGES-1];
  assign seq_state = state;

  always_ff @(posedge clk_200 or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      state       <= ST_ASSERT;
      hold_cnt    <= '0;
      gap_cnt     <= '0;
      stage       <= '0;
      rst_out     <= '1;
      seq_done    <= 1'b0;
      reset_count <= '0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], locked};
      state       <= state_d;
      hold_cnt    <= hold_cnt_d;
      gap_cnt     <= gap_cnt_d;
      stage       <= stage_d;
      rst_out     <= rst_out_d;
      seq_done    <= seq_done_d;
      reset_count <= reset_count_d;
    end
  end

  // Lock loss takes priority over counter completion in HOLD and RELEASE.
  always_comb begin
    state_d       = state;
    hold_cnt_d    = hold_cnt;
    gap_cnt_d     = gap_cnt;
    stage_d       = stage;
    rst_out_d     = rst_out;
    seq_done_d    = seq_done;
    reset_count_d = reset_count;
    case (state)
      ST_ASSERT: begin
        rst_out_d  = '1;
        seq_done_d = 1'b0;
        hold_cnt_d = '0;
        gap_cnt_d  = '0;
        stage_d    = '0;
        state_d    = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end
      ST_HOLD: begin
        if (!locked_s) begin
          state_d    = ST_WAIT_LOCK;
          hold_cnt_d = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          hold_cnt_d   = '0;
          gap_cnt_d    = '0;
          stage_d      = SW'(1);
          rst_out_d[0] = 1'b0;
          if (NUM_STAGES == 1) begin
            state_d    = ST_RUN;
            seq_done_d = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          hold_cnt_d = hold_cnt + HW'(1);
        end
      end
      ST_RELEASE: begin
        if (!locked_s) begin
          state_d   = ST_ASSERT;
          rst_out_d = '1;
          gap_cnt_d = '0;
          stage_d   = '0;
        end else if (gap_cnt == GAP_LAST) begin
          gap_cnt_d        = '0;
          rst_out_d[stage] = 1'b0;
          if (stage == STAGE_LAST) begin
            state_d    = ST_RUN;
            seq_done_d = 1'b1;
            stage_d    = '0;
          end else begin
            stage_d = stage + SW'(1);
          end
        end else begin
          gap_cnt_d = gap_cnt + GW'(1);
        end
      end
      ST_RUN: begin
        if (!locked_s || sw_reset_req) begin
          state_d    = ST_ASSERT;
          rst_out_d  = '1;
          seq_done_d = 1'b0;
          if (reset_count != 8'hFF) reset_count_d = reset_count + 8'd1;
        end
      end
      default: begin
        state_d    = ST_ASSERT;
        rst_out_d  = '1;
        seq_done_d = 1'b0;
      end
    endcase
  end

endmodule
